// File: rtl/burst_mem_pkg.sv
// Shared types, default sizes and the parity helper for the burst memory.
package burst_mem_pkg;

   localparam int unsigned DEF_DATA_W = 16;
   localparam int unsigned DEF_ADDR_W = 15;
   localparam int unsigned DEF_LEN_W  = 4;
   localparam int unsigned PAR_MAX_W  = 64;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2
   } state_e;

   // Even parity: the stored bit makes the XOR of data plus parity zero.
   // Callers zero-extend to PAR_MAX_W, which leaves the parity unchanged.
   function automatic logic even_par(input logic [PAR_MAX_W-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/burst_mem_array.sv
// Synchronous 1R/1W storage array with registered, read-enabled output.
module burst_mem_array #(
   parameter int unsigned WIDTH = 17,
   parameter int unsigned AW    = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_re,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   localparam int unsigned DEPTH = 1 << AW;

   logic [WIDTH-1:0] r_mem [0:DEPTH-1];
   logic [WIDTH-1:0] r_q;

   // Storage itself carries no reset.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Output register only loads on a read, so it holds while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q <= '0;
      end else if (i_re) begin
         r_q <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_q;

endmodule

// File: rtl/burst_mem.sv
// Burst-addressed single-port memory: command, write-beat and read-beat handshakes.
// Optional BURST_MEM_PARITY_EN stores an even-parity bit per word and flags mismatches on rerr.
module burst_mem
   import burst_mem_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned LEN_W  = DEF_LEN_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_we,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic [DATA_W-1:0] wdata,
   input  logic              wvalid,
   output logic              wready,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid,
   input  logic              rready,
   output logic              rlast,
   output logic              rerr,
   output logic              busy
);

`ifdef BURST_MEM_PARITY_EN
   localparam int unsigned MEM_W = DATA_W + 1;
`else
   localparam int unsigned MEM_W = DATA_W;
`endif

   state_e            r_state;
   state_e            w_state_nxt;
   logic [ADDR_W-1:0] r_ptr;
   logic [LEN_W-1:0]  r_cnt;
   logic              r_issue_done;
   logic              r_rvalid;
   logic              r_rlast;

   logic              w_cmd_hs;
   logic              w_wr_hs;
   logic              w_rd_hs;
   logic              w_re;
   logic [MEM_W-1:0]  w_wword;
   logic [MEM_W-1:0]  w_rword;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and handshake decode.
   always_comb begin
      w_state_nxt = r_state;
      w_cmd_hs    = 1'b0;
      w_wr_hs     = 1'b0;
      w_rd_hs     = 1'b0;
      w_re        = 1'b0;
      case (r_state)
         IDLE: begin
            if (cmd_valid) begin
               w_cmd_hs    = 1'b1;
               w_state_nxt = cmd_we ? WRITE : READ;
            end
         end
         WRITE: begin
            if (wvalid) begin
               w_wr_hs = 1'b1;
               if (r_cnt == '0) begin
                  w_state_nxt = IDLE;
               end
            end
         end
         READ: begin
            w_rd_hs = r_rvalid && rready;
            // Refill the output register when it is empty or draining this cycle.
            w_re    = !r_issue_done && (!r_rvalid || rready);
            if (w_rd_hs && r_rlast) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Burst pointer, beat counter and read-output flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr        <= '0;
         r_cnt        <= '0;
         r_issue_done <= 1'b0;
         r_rvalid     <= 1'b0;
         r_rlast      <= 1'b0;
      end else begin
         if (w_cmd_hs) begin
            r_ptr        <= cmd_addr;
            r_cnt        <= cmd_len;
            r_issue_done <= 1'b0;
         end else if (w_wr_hs || w_re) begin
            r_ptr <= r_ptr + ADDR_W'(1);
            if (r_cnt != '0) begin
               r_cnt <= r_cnt - LEN_W'(1);
            end
         end
         if (w_re) begin
            r_issue_done <= (r_cnt == '0);
            r_rvalid     <= 1'b1;
            r_rlast      <= (r_cnt == '0);
         end else if (w_rd_hs) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
         end
      end
   end

`ifdef BURST_MEM_PARITY_EN
   assign w_wword = {even_par(PAR_MAX_W'(wdata)), wdata};
   assign rerr    = r_rvalid & (w_rword[DATA_W] ^ even_par(PAR_MAX_W'(w_rword[DATA_W-1:0])));
`else
   assign w_wword = wdata;
   assign rerr    = 1'b0;
`endif

   burst_mem_array #(
      .WIDTH (MEM_W),
      .AW    (ADDR_W)
   ) u_array (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_we    (w_wr_hs),
      .i_waddr (r_ptr),
      .i_wdata (w_wword),
      .i_re    (w_re),
      .i_raddr (r_ptr),
      .o_rdata (w_rword)
   );

   assign rdata     = w_rword[DATA_W-1:0];
   assign rvalid    = r_rvalid;
   assign rlast     = r_rlast;
   assign cmd_ready = (r_state == IDLE);
   assign wready    = (r_state == WRITE);
   assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_burst_mem.sv
// Directed self-checking bench for burst_mem (default sizes 16/15/4).
module tb_burst_mem;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_we;
   logic [14:0] cmd_addr;
   logic [3:0]  cmd_len;
   logic [15:0] wdata;
   logic        wvalid;
   logic        wready;
   logic [15:0] rdata;
   logic        rvalid;
   logic        rready;
   logic        rlast;
   logic        rerr;
   logic        busy;

   int checks = 0;
   int errors = 0;

   // Captured read-burst results.
   logic [15:0] g_data [16];
   logic        g_last [16];
   logic        g_err  [16];
   logic [15:0] g_hold [8];
   logic        g_hold_last [8];
   int          g_nb;
   int          g_first;
   int          g_cyc;
   logic        g_end_ready;
   logic        g_end_rvalid;

   burst_mem dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_we    (cmd_we),
      .cmd_addr  (cmd_addr),
      .cmd_len   (cmd_len),
      .wdata     (wdata),
      .wvalid    (wvalid),
      .wready    (wready),
      .rdata     (rdata),
      .rvalid    (rvalid),
      .rready    (rready),
      .rlast     (rlast),
      .rerr      (rerr),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   // Starts at a negedge with the DUT idle; ends at the negedge after the last beat.
   task automatic write_burst(input logic [14:0] addr, input logic [3:0] len, input logic [15:0] base);
      cmd_valid = 1'b1;
      cmd_we    = 1'b1;
      cmd_addr  = addr;
      cmd_len   = len;
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         wvalid = 1'b1;
         wdata  = base + 16'(i);
         @(negedge clk);
      end
      wvalid = 1'b0;
   endtask

   // Issues a read burst, optionally stalling rready at one beat; captures what is seen.
   task automatic read_burst(input logic [14:0] addr, input logic [3:0] len,
                             input int stall_beat, input int stall_n);
      int stalled;
      stalled   = 0;
      cmd_valid = 1'b1;
      cmd_we    = 1'b0;
      cmd_addr  = addr;
      cmd_len   = len;
      rready    = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      g_cyc     = 1;
      g_nb      = 0;
      g_first   = -1;
      while (g_nb <= int'(len) && g_cyc < 64) begin
         if (rvalid && g_first < 0) g_first = g_cyc;
         if (rvalid && g_nb == stall_beat && stalled < stall_n) begin
            rready = 1'b0;
            g_hold[stalled]      = rdata;
            g_hold_last[stalled] = rlast;
            stalled++;
         end else begin
            rready = 1'b1;
         end
         if (rvalid && rready) begin
            g_data[g_nb] = rdata;
            g_last[g_nb] = rlast;
            g_err[g_nb]  = rerr;
            g_nb++;
         end
         @(negedge clk);
         g_cyc++;
      end
      g_end_ready  = cmd_ready;
      g_end_rvalid = rvalid;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
      wdata = '0; wvalid = 1'b0; rready = 1'b0;
      #12;
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (wready !== 1'b0) begin errors++; $display("FAIL reset_wready got %b exp 0", wready); end
      checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b exp 0", rvalid); end
      checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata got %h exp 0000", rdata); end
      checks++; if (rlast !== 1'b0 || rerr !== 1'b0) begin errors++; $display("FAIL reset_rlast_rerr got %b%b exp 00", rlast, rerr); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_write_read();
      logic [15:0] exp_d;
      write_burst(15'h0010, 4'd3, 16'hA001);
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_done_cmd_ready got %b exp 1", cmd_ready); end
      read_burst(15'h0010, 4'd3, -1, 0);
      checks++; if (g_nb !== 4) begin errors++; $display("FAIL rd_beats got %0d exp 4", g_nb); end
      checks++; if (g_first !== 2) begin errors++; $display("FAIL rd_latency got %0d exp 2", g_first); end
      checks++; if (g_cyc !== 6) begin errors++; $display("FAIL rd_no_bubbles end cycle got %0d exp 6", g_cyc); end
      for (int i = 0; i < 4; i++) begin
         exp_d = 16'hA001 + 16'(i);
         checks++; if (g_data[i] !== exp_d) begin errors++; $display("FAIL rd_data[%0d] got %h exp %h", i, g_data[i], exp_d); end
         checks++; if (g_last[i] !== (i == 3)) begin errors++; $display("FAIL rd_rlast[%0d] got %b exp %b", i, g_last[i], (i == 3)); end
      end
      checks++; if (g_end_ready !== 1'b1) begin errors++; $display("FAIL rd_end_cmd_ready got %b exp 1", g_end_ready); end
      checks++; if (g_end_rvalid !== 1'b0) begin errors++; $display("FAIL rd_end_rvalid got %b exp 0", g_end_rvalid); end
   endtask

   task automatic test_backpressure();
      logic [15:0] exp_d;
      write_burst(15'h0100, 4'd3, 16'hB001);
      read_burst(15'h0100, 4'd3, 1, 3);
      checks++; if (g_nb !== 4) begin errors++; $display("FAIL bp_beats got %0d exp 4", g_nb); end
      checks++; if (g_cyc !== 9) begin errors++; $display("FAIL bp_end_cycle got %0d exp 9", g_cyc); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (g_hold[i] !== 16'hB002 || g_hold_last[i] !== 1'b0) begin
            errors++; $display("FAIL bp_hold[%0d] got %h/%b exp B002/0", i, g_hold[i], g_hold_last[i]);
         end
      end
      for (int i = 0; i < 4; i++) begin
         exp_d = 16'hB001 + 16'(i);
         checks++; if (g_data[i] !== exp_d || g_last[i] !== (i == 3)) begin
            errors++; $display("FAIL bp_data[%0d] got %h/%b exp %h/%b", i, g_data[i], g_last[i], exp_d, (i == 3));
         end
      end
      checks++; if (g_end_ready !== 1'b1) begin errors++; $display("FAIL bp_end_cmd_ready got %b exp 1", g_end_ready); end
   endtask

   task automatic test_wrap();
      logic [15:0] exp_d;
      write_burst(15'h7FFE, 4'd3, 16'hC001);
      read_burst(15'h7FFE, 4'd3, -1, 0);
      for (int i = 0; i < 4; i++) begin
         exp_d = 16'hC001 + 16'(i);
         checks++; if (g_data[i] !== exp_d) begin errors++; $display("FAIL wrap_data[%0d] got %h exp %h", i, g_data[i], exp_d); end
      end
      read_burst(15'h0000, 4'd1, -1, 0);
      checks++; if (g_data[0] !== 16'hC003) begin errors++; $display("FAIL wrap_addr0 got %h exp C003", g_data[0]); end
      checks++; if (g_data[1] !== 16'hC004 || g_last[1] !== 1'b1) begin
         errors++; $display("FAIL wrap_addr1 got %h/%b exp C004/1", g_data[1], g_last[1]);
      end
   endtask

   task automatic test_reset_mid_burst();
      write_burst(15'h0200, 4'd3, 16'hD001);
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 15'h0200; cmd_len = 4'd3;
      @(negedge clk);
      cmd_valid = 1'b0;
      wvalid = 1'b1; wdata = 16'hE001;
      @(negedge clk);
      wdata = 16'hE002;
      @(negedge clk);
      wdata = 16'hE003;
      rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
         errors++; $display("FAIL rst_mid_async busy/cmd_ready got %b/%b exp 0/1", busy, cmd_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      wvalid = 1'b0;
      checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || wready !== 1'b0) begin
         errors++; $display("FAIL rst_mid_release busy/cmd_ready/wready got %b/%b/%b exp 0/1/0", busy, cmd_ready, wready);
      end
      read_burst(15'h0200, 4'd3, -1, 0);
      checks++; if (g_data[0] !== 16'hE001 || g_data[1] !== 16'hE002) begin
         errors++; $display("FAIL rst_mid_written got %h %h exp E001 E002", g_data[0], g_data[1]);
      end
      checks++; if (g_data[2] !== 16'hD003) begin errors++; $display("FAIL rst_mid_third got %h exp D003", g_data[2]); end
      checks++; if (g_data[3] !== 16'hD004) begin errors++; $display("FAIL rst_mid_fourth got %h exp D004", g_data[3]); end
   endtask

   task automatic test_parity();
      logic exp_err0;
      write_burst(15'h0400, 4'd1, 16'h1234);
`ifdef BURST_MEM_PARITY_EN
      dut.u_array.r_mem[1024][0] = ~dut.u_array.r_mem[1024][0];
      exp_err0 = 1'b1;
      read_burst(15'h0400, 4'd1, -1, 0);
      checks++; if (g_data[0] !== 16'h1235) begin errors++; $display("FAIL par_flipped_data got %h exp 1235", g_data[0]); end
`else
      exp_err0 = 1'b0;
      read_burst(15'h0400, 4'd1, -1, 0);
      checks++; if (g_data[0] !== 16'h1234) begin errors++; $display("FAIL par_data got %h exp 1234", g_data[0]); end
`endif
      checks++; if (g_err[0] !== exp_err0) begin errors++; $display("FAIL par_rerr0 got %b exp %b", g_err[0], exp_err0); end
      checks++; if (g_err[1] !== 1'b0) begin errors++; $display("FAIL par_rerr1 got %b exp 0", g_err[1]); end
      checks++; if (g_data[1] !== 16'h1235) begin errors++; $display("FAIL par_data1 got %h exp 1235", g_data[1]); end
   endtask

   task automatic test_back_to_back();
      write_burst(15'h0300, 4'd0, 16'hF00D);
      write_burst(15'h0301, 4'd0, 16'hBEEF);
      read_burst(15'h0300, 4'd0, -1, 0);
      checks++; if (g_nb !== 1 || g_data[0] !== 16'hF00D || g_last[0] !== 1'b1) begin
         errors++; $display("FAIL b2b_rd0 got n=%0d %h/%b exp n=1 F00D/1", g_nb, g_data[0], g_last[0]);
      end
      checks++; if (g_cyc !== 3) begin errors++; $display("FAIL b2b_rd0_end got %0d exp 3", g_cyc); end
      read_burst(15'h0301, 4'd0, -1, 0);
      checks++; if (g_nb !== 1 || g_data[0] !== 16'hBEEF || g_last[0] !== 1'b1) begin
         errors++; $display("FAIL b2b_rd1 got n=%0d %h/%b exp n=1 BEEF/1", g_nb, g_data[0], g_last[0]);
      end
      checks++; if (g_end_ready !== 1'b1 || g_end_rvalid !== 1'b0) begin
         errors++; $display("FAIL b2b_end got %b/%b exp 1/0", g_end_ready, g_end_rvalid);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_backpressure();
      test_wrap();
      test_reset_mid_burst();
      test_parity();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
